// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator. One synchronized trigger edge starts a
// sequence: each channel waits its own delay, then drives a pulse of its own
// duration. All timing is counted in ticks of a single-clock prescaler enable.
module pulse_train_gen #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 17
) (
  input  logic                  clk_Pulse,
  input  logic                  rst_n,
  input  logic [1:0]            CHTS,
  input  logic [1:0]            pl_mlt,
  input  logic                  PL_start,
  input  logic                  PL_launch,
  input  logic [N_CH*CNT_W-1:0] delay,
  input  logic [N_CH*CNT_W-1:0] duration,
  output logic [N_CH-1:0]       PL_out,
  output logic                  launch_DL,
  output logic                  busy
);

  // Wide enough to hold 99999, the terminal count of the slowest timebase.
  localparam int PS_W = 17;

  typedef enum logic [1:0] {CH_IDLE, CH_DELAY, CH_HIGH, CH_DONE} ch_state_e;

  logic [1:0]       start_sync_q, launch_sync_q, flush_q;
  logic             armed_q, armed_d;
  logic [1:0]       chts_q, chts_d, mlt_q, mlt_d;
  logic             busy_q, busy_d, launch_q, launch_d;
  logic [N_CH-1:0]  pl_q, pl_d;
  logic [PS_W-1:0]  presc_q, presc_d, term_w;
  ch_state_e        st_q [N_CH];
  ch_state_e        st_d [N_CH];
  logic [CNT_W-1:0] dcnt_q [N_CH];
  logic [CNT_W-1:0] dcnt_d [N_CH];
  logic [CNT_W-1:0] hcnt_q [N_CH];
  logic [CNT_W-1:0] hcnt_d [N_CH];
  logic [CNT_W-1:0] dur_q  [N_CH];
  logic [CNT_W-1:0] dur_d  [N_CH];
  logic             active_w, trig_w, start_w, tick_w, all_done_w;

  function automatic logic sel_trig(input logic [1:0] src, input logic s, input logic l);
    logic r;
    case (src)
      2'd1:    r = s;
      2'd2:    r = l;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Prescaler terminal count (period minus one); frozen mode never reaches a tick.
  function automatic logic [PS_W-1:0] tick_term(input logic [1:0] m);
    logic [PS_W-1:0] r;
    case (m)
      2'd1:    r = PS_W'(99);
      2'd2:    r = PS_W'(99999);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Trigger qualification, tick generation and per-channel next-state logic.
  always_comb begin
    active_w   = busy_q | launch_q;
    // While a sequence (or its completion hold) is live, only the latched source matters.
    trig_w     = sel_trig(active_w ? chts_q : CHTS, start_sync_q[1], launch_sync_q[1]);
    start_w    = !active_w && armed_q && trig_w;
    term_w     = tick_term(mlt_q);
    tick_w     = (mlt_q != 2'd3) && (presc_q == term_w);
    // Arm only once the synchronizers hold real samples, so a trigger that is
    // already high when reset releases is not mistaken for a rising edge.
    armed_d    = flush_q[1] & ~trig_w;
    all_done_w = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (st_q[i] != CH_DONE) all_done_w = 1'b0;
    end

    presc_d  = (start_w || presc_q == term_w) ? '0 : presc_q + PS_W'(1);
    chts_d   = chts_q;
    mlt_d    = mlt_q;
    busy_d   = busy_q;
    launch_d = launch_q;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]   = st_q[i];
      dcnt_d[i] = dcnt_q[i];
      hcnt_d[i] = hcnt_q[i];
      dur_d[i]  = dur_q[i];
    end

    if (start_w) begin
      chts_d   = CHTS;
      mlt_d    = pl_mlt;
      busy_d   = 1'b1;
      launch_d = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        st_d[i]   = CH_DELAY;
        dcnt_d[i] = delay[i*CNT_W +: CNT_W];
        dur_d[i]  = duration[i*CNT_W +: CNT_W];
      end
    end else if (active_w && !trig_w) begin
      busy_d   = 1'b0;
      launch_d = 1'b0;
      for (int i = 0; i < N_CH; i++) st_d[i] = CH_IDLE;
    end else if (busy_q) begin
      for (int i = 0; i < N_CH; i++) begin
        case (st_q[i])
          CH_DELAY: begin
            if (dcnt_q[i] == '0) begin
              if (dur_q[i] == '0) begin
                st_d[i] = CH_DONE;
              end else begin
                st_d[i]   = CH_HIGH;
                // A tick coinciding with entry (only at 1 clk/tick) already counts.
                hcnt_d[i] = dur_q[i] - CNT_W'(tick_w);
              end
            end else if (tick_w) begin
              dcnt_d[i] = dcnt_q[i] - CNT_W'(1);
            end
          end
          CH_HIGH: begin
            if (hcnt_q[i] == '0) st_d[i] = CH_DONE;
            else if (tick_w)     hcnt_d[i] = hcnt_q[i] - CNT_W'(1);
          end
          default: ;
        endcase
      end
      if (all_done_w) begin
        busy_d   = 1'b0;
        launch_d = 1'b1;
      end
    end

    for (int i = 0; i < N_CH; i++) pl_d[i] = (st_d[i] == CH_HIGH);
  end

  // Control state, synchronizers and registered outputs.
  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      start_sync_q  <= '0;
      launch_sync_q <= '0;
      flush_q       <= '0;
      armed_q       <= 1'b0;
      chts_q        <= '0;
      mlt_q         <= '0;
      busy_q        <= 1'b0;
      launch_q      <= 1'b0;
      pl_q          <= '0;
      presc_q       <= '0;
      for (int i = 0; i < N_CH; i++) st_q[i] <= CH_IDLE;
    end else begin
      start_sync_q  <= {start_sync_q[0], PL_start};
      launch_sync_q <= {launch_sync_q[0], PL_launch};
      flush_q       <= {flush_q[0], 1'b1};
      armed_q       <= armed_d;
      chts_q        <= chts_d;
      mlt_q         <= mlt_d;
      busy_q        <= busy_d;
      launch_q      <= launch_d;
      pl_q          <= pl_d;
      presc_q       <= presc_d;
      for (int i = 0; i < N_CH; i++) st_q[i] <= st_d[i];
    end
  end

  // Per-channel counters and latched durations; always loaded before use.
  always_ff @(posedge clk_Pulse) begin
    for (int i = 0; i < N_CH; i++) begin
      dcnt_q[i] <= dcnt_d[i];
      hcnt_q[i] <= hcnt_d[i];
      dur_q[i]  <= dur_d[i];
    end
  end

  assign PL_out    = pl_q;
  assign launch_DL = launch_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: stimulus pushes expected output-change
// events {edge, busy, launch_DL, PL_out}; a monitor pops one per observed change.
module tb_pulse_train_gen;
  localparam int N_CH  = 4;
  localparam int CNT_W = 17;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            CHTS, pl_mlt;
  logic                  PL_start, PL_launch;
  logic [N_CH*CNT_W-1:0] delay, duration;
  logic [N_CH-1:0]       PL_out;
  logic                  launch_DL, busy;

  pulse_train_gen #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk_Pulse(clk), .rst_n(rst_n), .CHTS(CHTS), .pl_mlt(pl_mlt),
    .PL_start(PL_start), .PL_launch(PL_launch), .delay(delay),
    .duration(duration), .PL_out(PL_out), .launch_DL(launch_DL), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [5:0] val; int tid; } evt_t;
  evt_t       exp_q[$];
  evt_t       mon_e;
  logic [5:0] mon_cur;
  logic [5:0] prev_s = '0;
  int         cyc = 0;
  int         total = 0;
  int         fails = 0;
  int         e0;

  // Edge counter: after rising edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output vector must match the next expected event.
  always @(negedge clk) begin
    mon_cur = {busy, launch_DL, PL_out};
    if (mon_cur !== prev_s) begin
      total++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %b at edge %0d, need no change", mon_cur, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.val !== mon_cur) begin
          fails++;
          $display("FAIL event_t%0d: got %b at edge %0d, need %b at edge %0d",
                   mon_e.tid, mon_cur, cyc, mon_e.val, mon_e.cyc);
        end
      end
      prev_s = mon_cur;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [5:0] v, input int tid);
    evt_t e;
    e.cyc = c; e.val = v; e.tid = tid;
    exp_q.push_back(e);
  endtask

  task automatic set_ch(input int i, input int d, input int u);
    delay[i*CNT_W +: CNT_W]    = CNT_W'(d);
    duration[i*CNT_W +: CNT_W] = CNT_W'(u);
  endtask

  task automatic drain(input int tid);
    total++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_t%0d: got %0d pending events, need 0", tid, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({busy, launch_DL, PL_out} !== 6'b0) begin
      fails++;
      $display("FAIL %s: got %b, need 000000", name, {busy, launch_DL, PL_out});
    end
  endtask

  initial begin
    rst_n = 1'b0; CHTS = 2'd1; pl_mlt = 2'd0;
    PL_start = 1'b0; PL_launch = 1'b0; delay = '0; duration = '0;
    step(3);
    check_zero("reset_state");
    rst_n = 1'b1;
    step(2);

    // T1: four channels at 1 clk/tick.
    set_ch(0, 0, 4); set_ch(1, 3, 4); set_ch(2, 5, 2); set_ch(3, 10, 1);
    PL_start = 1'b1; e0 = cyc + 3;
    push(e0,      6'b10_0000, 1);
    push(e0 + 1,  6'b10_0001, 1);
    push(e0 + 4,  6'b10_0011, 1);
    push(e0 + 5,  6'b10_0010, 1);
    push(e0 + 6,  6'b10_0110, 1);
    push(e0 + 8,  6'b10_0000, 1);
    push(e0 + 11, 6'b10_1000, 1);
    push(e0 + 12, 6'b10_0000, 1);
    push(e0 + 13, 6'b01_0000, 1);
    step(20);
    PL_start = 1'b0; push(cyc + 3, 6'b00_0000, 1);
    step(6); drain(1);

    // T2: 100 clk/tick, channel 0 delay 2 duration 3.
    delay = '0; duration = '0; set_ch(0, 2, 3); pl_mlt = 2'd1;
    PL_start = 1'b1; e0 = cyc + 3;
    push(e0,       6'b10_0000, 2);
    push(e0 + 201, 6'b10_0001, 2);
    push(e0 + 501, 6'b10_0000, 2);
    push(e0 + 502, 6'b01_0000, 2);
    step(520);
    PL_start = 1'b0; push(cyc + 3, 6'b00_0000, 2);
    step(6); drain(2);

    // T3: trigger drop mid-HIGH, then a fresh sequence with full delay.
    delay = '0; duration = '0; set_ch(0, 2, 20); pl_mlt = 2'd0;
    PL_start = 1'b1; e0 = cyc + 3;
    push(e0,     6'b10_0000, 3);
    push(e0 + 3, 6'b10_0001, 3);
    step(8);
    PL_start = 1'b0; push(cyc + 3, 6'b00_0000, 3);
    step(6); drain(3);
    PL_start = 1'b1; e0 = cyc + 3;
    push(e0,      6'b10_0000, 4);
    push(e0 + 3,  6'b10_0001, 4);
    push(e0 + 23, 6'b10_0000, 4);
    push(e0 + 24, 6'b01_0000, 4);
    step(30);
    PL_start = 1'b0; push(cyc + 3, 6'b00_0000, 4);
    step(6); drain(4);

    // T4: CHTS=2 ignores PL_start; PL_launch starts; CHTS change does not abort.
    delay = '0; duration = '0; set_ch(0, 1, 2); CHTS = 2'd2;
    for (int k = 0; k < 3; k++) begin
      PL_start = 1'b1; step(4);
      PL_start = 1'b0; step(4);
    end
    drain(5);
    PL_launch = 1'b1; e0 = cyc + 3;
    push(e0,     6'b10_0000, 6);
    push(e0 + 2, 6'b10_0001, 6);
    push(e0 + 4, 6'b10_0000, 6);
    push(e0 + 5, 6'b01_0000, 6);
    step(4);
    CHTS = 2'd0;
    step(10);
    PL_launch = 1'b0; push(cyc + 3, 6'b00_0000, 6);
    step(6); drain(6);
    CHTS = 2'd1;

    // T5: all durations 0, delay 1: no pulses, launch_DL at E+3.
    for (int i = 0; i < N_CH; i++) set_ch(i, 1, 0);
    PL_start = 1'b1; e0 = cyc + 3;
    push(e0,     6'b10_0000, 7);
    push(e0 + 3, 6'b01_0000, 7);
    step(8);
    PL_start = 1'b0; push(cyc + 3, 6'b00_0000, 7);
    step(6); drain(7);

    // T6: asynchronous reset mid-HIGH; held trigger must not restart.
    delay = '0; duration = '0; set_ch(0, 0, 20);
    PL_start = 1'b1; e0 = cyc + 3;
    push(e0,     6'b10_0000, 8);
    push(e0 + 1, 6'b10_0001, 8);
    step(6);
    rst_n = 1'b0; push(cyc + 1, 6'b00_0000, 8);
    #1;
    check_zero("async_reset");
    step(2);
    rst_n = 1'b1;
    step(20); drain(8);
    PL_start = 1'b0; step(5);
    PL_start = 1'b1; e0 = cyc + 3;
    push(e0,      6'b10_0000, 9);
    push(e0 + 1,  6'b10_0001, 9);
    push(e0 + 21, 6'b10_0000, 9);
    push(e0 + 22, 6'b01_0000, 9);
    step(30);
    PL_start = 1'b0; push(cyc + 3, 6'b00_0000, 9);
    step(6); drain(9);

    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Multi-channel successor to the single-pulse generator. One external trigger starts a sequence in which each of N_CH channels waits its own programmed delay and then drives a pulse of its own programmed duration, all timed in ticks of a selectable timebase. The block replaces the derived divided clock with a single-clock tick enable. It sits between the trigger-selection logic and the optical driver outputs, and signals sequence completion to the downstream delay stage.

## Interface
- N_CH, 4, number of pulse channels (1..16)
- CNT_W, 17, width of per-channel delay and duration fields
- clk_Pulse  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- CHTS  in  2  trigger source: 1 = PL_start, 2 = PL_launch, 0/3 = disabled
- pl_mlt  in  2  timebase: 0 = 1 clk/tick, 1 = 100 clk/tick, 2 = 100000 clk/tick, 3 = frozen (no ticks)
- PL_start  in  1  trigger source 1, asynchronous level
- PL_launch  in  1  trigger source 2, asynchronous level
- delay  in  N_CH*CNT_W  per-channel delay in ticks; channel i occupies bits [i*CNT_W +: CNT_W]
- duration  in  N_CH*CNT_W  per-channel pulse width in ticks, packed as for delay
- PL_out  out  N_CH  pulse outputs
- launch_DL  out  1  all channels finished; held until the trigger drops
- busy  out  1  sequence in progress

## Operation
- PL_start and PL_launch each pass through a 2-FF synchronizer. trig is the synchronized level of the source selected by CHTS.
- Reset, asynchronous: all outputs 0, all channels IDLE, prescaler 0, synchronizers 0.
- Start: in IDLE with CHTS ∈ {1,2}, a 0→1 transition of trig starts a sequence. The start edge E is the clock edge at which the transition is detected.
- At E the block latches CHTS, pl_mlt, delay and duration. Changes to these inputs during the sequence have no effect. At E the prescaler is cleared and busy is set.
- Per-channel state machine: IDLE → DELAY → HIGH → DONE.
  - DELAY lasts delay[i] ticks; delay[i] = 0 skips directly to HIGH.
  - HIGH drives PL_out[i] = 1 for exactly duration[i] ticks; duration[i] = 0 goes straight to DONE and the channel never pulses.
  - Delay and duration use a separate down-count per phase, each CNT_W bits wide, so they never overflow. The maximum for each is 2^CNT_W − 1 ticks.
- Tick generator: one-cycle enable every T clocks, where T = 1, 100 or 100000 for latched pl_mlt = 0, 1 or 2. With pl_mlt = 3 no ticks occur, so channels hold their state and outputs.
- Completion: when every channel is in DONE, on the next edge launch_DL = 1 and busy = 0. launch_DL stays 1 while trig stays high.
- Trigger drop: trig = 0 in any state returns all channels to IDLE on the next edge, with PL_out = 0, launch_DL = 0 and busy = 0. This aborts any in-flight sequence; no partial pulse continues.
- Retrigger: a 0→1 transition is required to start again. A trig that stays high after completion does not restart the sequence.
- CHTS is latched, so an external change of CHTS during a sequence does not abort it. The source monitored for the drop is the latched one.
- Start and drop detected on the same edge cannot occur, because each requires a different trig level.

## Timing
- Trigger input rising with setup before edge k: sync stage 1 captures at k, stage 2 at k+1, and the start is detected at E = k+2.
- PL_out[i] rises at edge E + 1 + delay[i]·T.
- PL_out[i] falls at edge E + 1 + (delay[i] + duration[i])·T.
- launch_DL rises one edge after the last channel's fall. With all durations 0, it rises one edge after the latest-delay channel enters DONE.
- Trigger falling input to all outputs low: 3 edges (2 for synchronization, 1 for the state update).
- Skew between channels with equal delay and duration: 0 clocks.

## Test plan
- N_CH = 4, CHTS = 1, pl_mlt = 0, delays 0/3/5/10, durations 4/4/2/1, PL_start pulses high and stays high:
  - PL_out[0..3] high over edges E+1..E+4, E+4..E+7, E+6..E+7 and E+11 (single edge).
  - launch_DL rises at E+13 and busy falls at E+13.
- pl_mlt = 1, delay = 2, duration = 3 on channel 0 → PL_out[0] high from E+201 to E+501 (300 clocks).
- PL_start drops mid-HIGH → PL_out, launch_DL and busy are all 0 three edges after the input falls. Re-raising PL_start starts a fresh sequence with full delay.
- CHTS = 2 with PL_start toggling → no activity. A PL_launch rise then starts a sequence. Changing CHTS to 0 mid-sequence does not abort it.
- duration = 0 on all channels, delay = 1 → PL_out never asserts; launch_DL asserts at E+3.
- Reset asserted mid-HIGH → outputs 0 immediately without a clock edge. After release, a held-high trigger does not start a sequence until it has gone 0→1.
